// File: rtl/roll_step_ctrl.sv
// roll_step_ctrl: switch synchroniser/debouncer, mode priority encoder and step-strobe prescaler
module roll_step_ctrl #(
   parameter int CLK_HZ       = 50000000,
   parameter int STEP_HZ      = 2,
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic [2:0] SW,
   output logic [2:0] sw_clean,
   output logic [1:0] mode,
   output logic       step
);
   localparam int DIV = CLK_HZ / STEP_HZ;
   localparam int DW  = $clog2(DEBOUNCE_CYC);
   localparam int PW  = $clog2(DIV);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);

   logic [2:0]    s1_q, s2_q, clean_q, clean_d;
   logic [DW-1:0] cnt_q [3];
   logic [DW-1:0] cnt_d [3];
   logic [1:0]    mode_q, mode_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          step_q, step_d;

   // per-bit debounce: any return to the accepted level restarts the stability window
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         clean_d[i] = clean_q[i];
         cnt_d[i]   = '0;
         if (s2_q[i] != clean_q[i]) begin
            if (cnt_q[i] == DB_LAST) clean_d[i] = s2_q[i];
            else cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // mode priority, prescaler restart on mode change, and wrap-driven step
   always_comb begin
      mode_d  = clean_q[2] ? 2'd3 : clean_q[1] ? 2'd2 : clean_q[0] ? 2'd1 : 2'd0;
      presc_d = (mode_d != mode_q || mode_q == 2'd0 || presc_q == P_LAST) ? '0 : presc_q + 1'b1;
      step_d  = mode_q != 2'd0 && mode_d == mode_q && presc_q == P_LAST;
   end

   // state registers, cleared immediately by RESET
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         s1_q    <= '0;
         s2_q    <= '0;
         clean_q <= '0;
         cnt_q   <= '{default: '0};
         mode_q  <= '0;
         presc_q <= '0;
         step_q  <= 1'b0;
      end else begin
         s1_q    <= SW;
         s2_q    <= s1_q;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         presc_q <= presc_d;
         step_q  <= step_d;
      end
   end

   assign sw_clean = clean_q;
   assign mode     = mode_q;
   assign step     = step_q;
endmodule

// File: tb/tb_roll_step_ctrl.sv
// tb_roll_step_ctrl: directed checks of debounce, mode priority and step timing (DIV=10, DEBOUNCE_CYC=4)
module tb_roll_step_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] sw  = 3'b000;
   logic [2:0] sw_clean;
   logic [1:0] mode;
   logic       step;
   int         tests = 0;
   int         fails = 0;
   int         nsteps;
   bit         ok;

   roll_step_ctrl #(.CLK_HZ(100), .STEP_HZ(10), .DEBOUNCE_CYC(4)) dut (
      .CLOCK_50(clk),
      .RESET(rst),
      .SW(sw),
      .sw_clean(sw_clean),
      .mode(mode),
      .step(step)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      sw = 3'b111;
      repeat (3) tick();
      chk("rst_sw_clean", sw_clean, 0);
      chk("rst_mode", mode, 0);
      chk("rst_step", step, 0);
      rst = 1'b0;
      repeat (5) tick();
      chk("rel_clean_e5", sw_clean, 0);
      tick();
      chk("rel_clean_e6", sw_clean, 3'b111);
      chk("rel_mode_e6", mode, 0);
      tick();
      chk("rel_mode_e7", mode, 3);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      sw = 3'b001;
      nsteps = 0;
      ok = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (e == 6) chk("single_mode_e6", mode, 0);
         if (e == 7) chk("single_mode_e7", mode, 1);
         if (step) begin
            nsteps++;
            if (!(e == 17 || e == 27 || e == 37)) ok = 1'b0;
         end
      end
      chk("single_step_count", nsteps, 3);
      chk("single_step_edges", ok, 1);

      sw = 3'b101;
      nsteps = 0;
      ok = 1'b1;
      for (int e = 41; e <= 70; e++) begin
         tick();
         if (e == 46) chk("prio_mode_e46", mode, 1);
         if (e == 47) chk("prio_mode_e47", mode, 3);
         if (step) begin
            nsteps++;
            if (!(e == 57 || e == 67)) ok = 1'b0;
         end
      end
      chk("prio_step_count", nsteps, 2);
      chk("prio_step_edges", ok, 1);

      sw = 3'b000;
      nsteps = 0;
      for (int e = 71; e <= 180; e++) begin
         tick();
         if (e == 76) chk("idle_mode_e76", mode, 3);
         if (e == 77) chk("idle_mode_e77", mode, 0);
         if (step) nsteps++;
      end
      chk("idle_no_step", nsteps, 0);

      ok = 1'b1;
      for (int r = 0; r < 5; r++) begin
         sw = 3'b001;
         repeat (3) begin
            tick();
            if (sw_clean != 0 || mode != 0 || step) ok = 1'b0;
         end
         sw = 3'b000;
         repeat (3) begin
            tick();
            if (sw_clean != 0 || mode != 0 || step) ok = 1'b0;
         end
      end
      repeat (4) begin
         tick();
         if (sw_clean != 0 || mode != 0 || step) ok = 1'b0;
      end
      chk("bounce_quiet", ok, 1);
      chk("bounce_clean", sw_clean, 0);

      sw = 3'b010;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 7) chk("async_pre_mode", mode, 2);
         if (k == 15) chk("async_pre_step", step, 0);
      end
      #2 rst = 1'b1;
      #1;
      chk("async_clean", sw_clean, 0);
      chk("async_mode", mode, 0);
      chk("async_step", step, 0);
      #2 rst = 1'b0;
      nsteps = 0;
      for (int e = 1; e <= 17; e++) begin
         tick();
         if (e == 6) chk("post_mode_e6", mode, 0);
         if (e == 7) chk("post_mode_e7", mode, 2);
         if (e <= 16 && step) nsteps++;
         if (e == 17) chk("post_step_e17", step, 1);
      end
      chk("post_no_early_step", nsteps, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
